// File: rtl/registrador_universal.sv
// Universal shift register: hold, shift right, shift left and parallel load, with a saturating shift counter and a word-complete pulse.
// Optional ROTATE_EN adds a rotate input that recirculates the outgoing bit in place of the serial inputs.
module registrador_universal #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             entrada_dir,
  input  logic             entrada_esq,
`ifdef ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mode_t            mode_e;
  logic             bit_dir;
  logic             bit_esq;
  logic             is_shift;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] count_next;
  logic             done_next;

  assign mode_e = mode_t'(mode);

`ifdef ROTATE_EN
  assign bit_dir = rotate ? q[0]       : entrada_dir;
  assign bit_esq = rotate ? q[WIDTH-1] : entrada_esq;
`else
  assign bit_dir = entrada_dir;
  assign bit_esq = entrada_esq;
`endif

  always_comb begin
    serial_out = 1'b0;
    case (mode_e)
      MODE_RIGHT: serial_out = q[0];
      MODE_LEFT:  serial_out = q[WIDTH-1];
      default:    serial_out = 1'b0;
    endcase
  end

  always_comb begin
    q_next     = q;
    count_next = shift_count;
    done_next  = 1'b0;
    is_shift   = 1'b0;
    if (enable) begin
      case (mode_e)
        MODE_RIGHT: begin
          q_next   = {bit_dir, q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LEFT: begin
          q_next   = {q[WIDTH-2:0], bit_esq};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_next     = parallel_in;
          count_next = '0;
        end
        default: q_next = q;
      endcase
      // Pulse only on the shift that completes the word; saturated shifts stay quiet.
      if (is_shift && (shift_count != CNT_FULL)) begin
        count_next = shift_count + 1'b1;
        done_next  = (shift_count == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q           <= '0;
      shift_count <= '0;
      word_done   <= 1'b0;
    end else begin
      q           <= q_next;
      shift_count <= count_next;
      word_done   <= done_next;
    end
  end

endmodule
